// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: state encoding and default widths shared by the rom_arbiter slice
package rom_arb_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search, first set bit above ptr (wrapping)
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);
  logic [IW-1:0] idx;
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any          = 1'b1;
        win_oh[idx]  = 1'b1;
        win_idx      = idx;
      end
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one rom16x4 read port with fixed access wait
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        dvalid,
  output logic [DATA_W-1:0]      datos_out,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [DATA_W-1:0]      rom_datos,
  output logic                   busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
  if (WAIT_CYC < 1) begin : g_bad_wait
    $error("WAIT_CYC must be at least 1");
  end
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d, win_q, win_d;
  logic [NREQ-1:0]     gnt_q, gnt_d, dvalid_q, dvalid_d;
  logic [DATA_W-1:0]   datos_q, datos_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [NREQ-1:0]     pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = addr_in[g*ADDR_W +: ADDR_W];
  end
  // A requester in its dvalid cycle still holds req; mask it to avoid a re-grant
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req & ~dvalid_q),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = '0;
    dvalid_d = '0;
    datos_d  = datos_q;
    addr_d   = addr_q;
    if (state_q == IDLE) begin
      if (pick_any) begin
        addr_d  = addr_arr[pick_idx];
        gnt_d   = pick_oh;
        win_d   = pick_idx;
        cnt_d   = CW'(WAIT_CYC - 1);
        state_d = WAIT;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      datos_d  = rom_datos;
      dvalid_d = NREQ'(1) << win_q;
      ptr_d    = win_q;
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      gnt_q    <= '0;
      dvalid_q <= '0;
      datos_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      dvalid_q <= dvalid_d;
      datos_q  <= datos_d;
      addr_q   <= addr_d;
    end
  end
  assign gnt         = gnt_q;
  assign dvalid      = dvalid_q;
  assign datos_out   = datos_q;
  assign rom_address = addr_q;
  assign busy        = (state_q == WAIT);
endmodule
